// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Reassembles one frame from the UART Rx byte stream. A frame is PAYLOAD_BYTES
// of payload followed by a 2-byte CRC16, sent MSB first. A bit-serial CRC16
// engine runs over every byte, including the received CRC, so a good frame
// leaves a zero residue. A good payload is then held on data_out with
// frame_valid until frame_ack. Bad, truncated and overrun frames are dropped,
// and each case raises a one-cycle error pulse.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   en           : receiver enable; low forces IDLE
//   rx_done      : one-cycle pulse, rx_data holds a new byte
//   rx_data      : byte from the UART Rx
//   rx_frame_err : one-cycle pulse, stop-bit error on the current byte
//   frame_ack    : downstream has taken data_out
//   data_out     : payload; first received byte in the MSBs
//   frame_valid  : data_out holds a CRC-checked frame
//   busy         : frame reception or delivery in progress
//   crc_err      : pulse, CRC residue nonzero
//   timeout_err  : pulse, inter-byte gap expired mid-frame
//   overrun_err  : pulse, byte arrived when it could not be accepted
//   frame_err    : pulse, UART framing error seen
module uart_rx_frame_ctrl #(
  parameter int          PAYLOAD_BYTES  = 16,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [15:0] CRC_POLY       = 16'h1021,
  parameter logic [15:0] CRC_INIT       = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       rx_done,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_frame_err,
  input  logic                       frame_ack,
  output logic [8*PAYLOAD_BYTES-1:0] data_out,
  output logic                       frame_valid,
  output logic                       busy,
  output logic                       crc_err,
  output logic                       timeout_err,
  output logic                       overrun_err,
  output logic                       frame_err
);

  localparam int CW = $clog2(PAYLOAD_BYTES + 3);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = 8 * PAYLOAD_BYTES;
  localparam logic [CW-1:0] CNT_PAYLOAD = CW'(PAYLOAD_BYTES);
  localparam logic [CW-1:0] CNT_FRAME   = CW'(PAYLOAD_BYTES + 2);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_CRC_SHIFT,
    S_CHECK,
    S_DELIVER
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [15:0]     r_crc, w_crc;
  logic [TW-1:0]   r_tmo, w_tmo;
  logic [7:0]      r_shift, w_shift;
  logic [2:0]      r_bit, w_bit;
  logic            r_abort, w_abort;
  logic [DW-1:0]   r_data, w_data;
  logic            r_valid, w_valid;
  logic            r_crc_err, w_crc_err;
  logic            r_tmo_err, w_tmo_err;
  logic            r_ovr_err, w_ovr_err;
  logic            r_fe_err, w_fe_err;
  // Errors seen in the cycle frame_valid rises are reported one cycle later.
  logic            r_pend_ovr, w_pend_ovr;
  logic            r_pend_fe, w_pend_fe;

  logic            w_ev_fe;
  logic            w_ev_ovr;
  logic [15:0]     w_crc_step;

  // A framing error outranks a simultaneous rx_done.
  assign w_ev_fe  = rx_frame_err;
  assign w_ev_ovr = rx_done && !rx_frame_err;

  assign w_crc_step = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ r_shift[7]) ? CRC_POLY : 16'h0000);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_crc      = r_crc;
    w_tmo      = r_tmo;
    w_shift    = r_shift;
    w_bit      = r_bit;
    w_abort    = r_abort;
    w_data     = r_data;
    w_valid    = r_valid;
    w_crc_err  = 1'b0;
    w_tmo_err  = 1'b0;
    w_ovr_err  = r_pend_ovr;
    w_fe_err   = r_pend_fe;
    w_pend_ovr = 1'b0;
    w_pend_fe  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state = S_WAIT_BYTE;
          w_cnt   = '0;
          w_crc   = CRC_INIT;
          w_tmo   = '0;
          w_abort = 1'b0;
        end
      end

      S_WAIT_BYTE: begin
        if (w_ev_fe) begin
          w_fe_err = 1'b1;
          w_cnt    = '0;
          w_crc    = CRC_INIT;
          w_tmo    = '0;
        end else if (rx_done) begin
          w_shift = rx_data;
          if (r_cnt < CNT_PAYLOAD) begin
            w_data = {r_data[DW-9:0], rx_data};
          end
          w_cnt   = r_cnt + 1'b1;
          w_tmo   = '0;
          w_bit   = '0;
          w_abort = 1'b0;
          w_state = S_CRC_SHIFT;
        end else if (r_cnt != '0) begin
          if (r_tmo == TMO_LAST) begin
            w_tmo_err = 1'b1;
            w_cnt     = '0;
            w_crc     = CRC_INIT;
            w_tmo     = '0;
          end else begin
            w_tmo = r_tmo + 1'b1;
          end
        end
      end

      S_CRC_SHIFT: begin
        w_crc   = w_crc_step;
        w_shift = {r_shift[6:0], 1'b0};
        w_bit   = r_bit + 1'b1;
        if (w_ev_fe) begin
          w_fe_err = 1'b1;
          w_abort  = 1'b1;
        end else if (w_ev_ovr) begin
          w_ovr_err = 1'b1;
          w_abort   = 1'b1;
        end
        if (r_bit == 3'd7) begin
          if (r_abort || w_ev_fe || w_ev_ovr) begin
            // Partial frame is discarded once the byte finishes shifting.
            w_state = S_WAIT_BYTE;
            w_cnt   = '0;
            w_crc   = CRC_INIT;
            w_abort = 1'b0;
          end else if (r_cnt == CNT_FRAME) begin
            w_state = S_CHECK;
          end else begin
            w_state = S_WAIT_BYTE;
          end
        end
      end

      S_CHECK: begin
        w_cnt   = '0;
        w_crc   = CRC_INIT;
        w_state = S_WAIT_BYTE;
        if (w_ev_fe) begin
          w_fe_err = 1'b1;
        end else if (w_ev_ovr) begin
          w_ovr_err = 1'b1;
        end else if (r_crc == 16'h0000) begin
          w_state = S_DELIVER;
        end else begin
          w_crc_err = 1'b1;
        end
      end

      S_DELIVER: begin
        // frame_valid rises on the edge after entry and stays until acked.
        if (r_valid && frame_ack) begin
          w_valid = 1'b0;
          w_state = S_WAIT_BYTE;
        end else begin
          w_valid = 1'b1;
        end
        if (r_valid) begin
          w_fe_err  = w_fe_err  | w_ev_fe;
          w_ovr_err = w_ovr_err | w_ev_ovr;
        end else begin
          w_pend_fe  = w_ev_fe;
          w_pend_ovr = w_ev_ovr;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Disable wins over everything; data_out keeps its contents.
    if (!en) begin
      w_state    = S_IDLE;
      w_valid    = 1'b0;
      w_cnt      = '0;
      w_crc      = CRC_INIT;
      w_tmo      = '0;
      w_abort    = 1'b0;
      w_crc_err  = 1'b0;
      w_tmo_err  = 1'b0;
      w_ovr_err  = 1'b0;
      w_fe_err   = 1'b0;
      w_pend_ovr = 1'b0;
      w_pend_fe  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_crc      <= CRC_INIT;
      r_tmo      <= '0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_abort    <= 1'b0;
      // NOTE: the payload register is a visible output with a defined reset
      // value, so it is reset like any control flop rather than left as
      // uninitialised storage.
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_crc_err  <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_ovr_err  <= 1'b0;
      r_fe_err   <= 1'b0;
      r_pend_ovr <= 1'b0;
      r_pend_fe  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_crc      <= w_crc;
      r_tmo      <= w_tmo;
      r_shift    <= w_shift;
      r_bit      <= w_bit;
      r_abort    <= w_abort;
      r_data     <= w_data;
      r_valid    <= w_valid;
      r_crc_err  <= w_crc_err;
      r_tmo_err  <= w_tmo_err;
      r_ovr_err  <= w_ovr_err;
      r_fe_err   <= w_fe_err;
      r_pend_ovr <= w_pend_ovr;
      r_pend_fe  <= w_pend_fe;
    end
  end

  assign data_out    = r_data;
  assign frame_valid = r_valid;
  assign busy        = !((r_state == S_IDLE) || ((r_state == S_WAIT_BYTE) && (r_cnt == '0)));
  assign crc_err     = r_crc_err;
  assign timeout_err = r_tmo_err;
  assign overrun_err = r_ovr_err;
  assign frame_err   = r_fe_err;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl with a 9-byte payload and a 50-cycle
// inter-byte timeout. Inputs change and outputs are sampled on the falling
// clock edge. A table of frames exercises good and bad CRCs. Hand-written
// sequences cover timeout, overrun, framing error, enable drop and
// asynchronous reset.
module tb_uart_rx_frame_ctrl;

  localparam int P   = 9;
  localparam int TMO = 50;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         rx_done = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_frame_err = 1'b0;
  logic         frame_ack = 1'b0;
  logic [8*P-1:0] data_out;
  logic         frame_valid, busy, crc_err, timeout_err, overrun_err, frame_err;

  uart_rx_frame_ctrl #(
    .PAYLOAD_BYTES (P),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .en          (en),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .rx_frame_err(rx_frame_err),
    .frame_ack   (frame_ack),
    .data_out    (data_out),
    .frame_valid (frame_valid),
    .busy        (busy),
    .crc_err     (crc_err),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cnt_crc = 0;
  int cnt_tmo = 0;
  int cnt_ovr = 0;
  int cnt_fe  = 0;

  // Error pulse tallies, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (crc_err)     cnt_crc++;
    if (timeout_err) cnt_tmo++;
    if (overrun_err) cnt_ovr++;
    if (frame_err)   cnt_fe++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [71:0] payload;
    logic [15:0] crc_lit;
    logic        use_model;
    logic [15:0] crc_xor;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  // Reference CRC16-CCITT (byte-wise form), seed FFFF, MSB first.
  function automatic logic [15:0] crc16_ref(input logic [71:0] p);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < 9; k++) begin
      c = c ^ {p[71-8*k -: 8], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Sends a full frame with 20-clock spacing, then checks the result
  // timing: crc_err 9 edges and frame_valid 10 edges after the last byte.
  task automatic run_frame(input logic [71:0] payload, input logic [15:0] crc,
                           input logic exp_valid, input string tag);
    int t0, o0, f0;
    logic [7:0] b;
    t0 = cnt_tmo;
    o0 = cnt_ovr;
    f0 = cnt_fe;
    for (int k = 0; k < P + 2; k++) begin
      if (k < P)       b = payload[71-8*k -: 8];
      else if (k == P) b = crc[15:8];
      else             b = crc[7:0];
      send_byte(b);
      if (k < P + 1) tick(19);
    end
    tick(8);
    check({tag, "_valid_e8"}, frame_valid, 1'b0);
    tick(1);
    check({tag, "_crc_err_e9"}, crc_err, !exp_valid);
    check({tag, "_valid_e9"}, frame_valid, 1'b0);
    tick(1);
    check({tag, "_valid_e10"}, frame_valid, exp_valid);
    check({tag, "_crc_err_e10"}, crc_err, 1'b0);
    if (exp_valid) check({tag, "_data"}, data_out, payload);
    check({tag, "_no_other_err"}, (cnt_tmo - t0) + (cnt_ovr - o0) + (cnt_fe - f0), 0);
  endtask

  task automatic ack_frame(input string tag);
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    check({tag, "_ack_valid_low"}, frame_valid, 1'b0);
    check({tag, "_ack_busy_low"}, busy, 1'b0);
  endtask

  task automatic run_vec(input int i, input logic do_ack);
    logic [15:0] c;
    c = (vecs[i].use_model ? crc16_ref(vecs[i].payload) : vecs[i].crc_lit) ^ vecs[i].crc_xor;
    run_frame(vecs[i].payload, c, vecs[i].exp_valid, $sformatf("vec%0d", i));
    if (vecs[i].exp_valid && do_ack) ack_frame($sformatf("vec%0d", i));
  endtask

  initial begin
    int seen;
    int c0;
    logic [71:0] exp_d;

    vecs[0] = '{72'h313233343536373839, 16'h29B1, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{72'h313233343536373839, 16'h29B0, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{72'h000000000000000000, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{72'hFFFFFFFFFFFFFFFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{72'h000102030405060708, 16'h0000, 1'b1, 16'h0100, 1'b0};

    // Reset state
    tick(2);
    check("rst_data", data_out, 72'h0);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_errs", {crc_err, timeout_err, overrun_err, frame_err}, 4'b0);
    rst_n = 1'b1;
    tick(1);
    en = 1'b1;
    tick(1);
    check("idle_busy", busy, 1'b0);

    // Table of frames: good, bad CRC, then good frames following a bad one
    for (int i = 0; i < 5; i++) run_vec(i, 1'b1);

    // Timeout: 3 bytes then silence; 8 CRC cycles plus 50 idle WAIT_BYTE cycles
    for (int k = 0; k < 3; k++) begin
      send_byte(vecs[0].payload[71-8*k -: 8]);
      if (k < 2) tick(19);
    end
    c0 = cnt_tmo;
    seen = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (i == 57) check("tmo_busy_before", busy, 1'b1);
      if (timeout_err) seen = i;
    end
    check("tmo_pulse_edge", seen, 58);
    check("tmo_pulse_count", cnt_tmo - c0, 1);
    check("tmo_busy_after", busy, 1'b0);
    run_vec(0, 1'b1);

    // Overrun while a frame is held in DELIVER
    run_vec(2, 1'b0);
    tick(3);
    send_byte(8'hAA);
    check("ovr_dlv_pulse", overrun_err, 1'b1);
    check("ovr_dlv_valid", frame_valid, 1'b1);
    check("ovr_dlv_data", data_out, vecs[2].payload);
    tick(1);
    check("ovr_dlv_single", overrun_err, 1'b0);
    ack_frame("ovr_dlv");
    run_vec(3, 1'b1);

    // Overrun during CRC_SHIFT: byte 3 clocks after byte 2
    c0 = cnt_crc;
    send_byte(8'h31);
    tick(19);
    send_byte(8'h32);
    tick(2);
    send_byte(8'h33);
    check("ovr_shift_pulse", overrun_err, 1'b1);
    tick(5);
    check("ovr_shift_dropped", busy, 1'b0);
    tick(10);
    check("ovr_shift_no_crc_err", cnt_crc - c0, 0);
    run_vec(0, 1'b1);

    // Enable drop mid-frame
    c0 = cnt_tmo + cnt_ovr + cnt_fe + cnt_crc;
    for (int k = 0; k < 5; k++) begin
      send_byte(8'hA1 + 8'(k));
      tick(19);
    end
    en = 1'b0;
    tick(1);
    exp_d = {vecs[0].payload[31:0], 40'hA1A2A3A4A5};
    check("en_busy", busy, 1'b0);
    check("en_valid", frame_valid, 1'b0);
    check("en_data_kept", data_out, exp_d);
    send_byte(8'h77);
    tick(3);
    check("en_idle_ignores", data_out, exp_d);
    check("en_no_err", cnt_tmo + cnt_ovr + cnt_fe + cnt_crc - c0, 0);
    en = 1'b1;
    tick(1);
    run_vec(2, 1'b1);

    // Framing error together with rx_done mid-frame: frame_err wins
    send_byte(8'h31);
    tick(19);
    send_byte(8'h32);
    tick(19);
    rx_data = 8'h55;
    rx_done = 1'b1;
    rx_frame_err = 1'b1;
    tick(1);
    rx_done = 1'b0;
    rx_frame_err = 1'b0;
    check("fe_pulse", frame_err, 1'b1);
    check("fe_no_ovr", overrun_err, 1'b0);
    check("fe_dropped", busy, 1'b0);
    run_vec(0, 1'b1);

    // Asynchronous reset mid-frame
    for (int k = 0; k < 4; k++) begin
      send_byte(vecs[3].payload[71-8*k -: 8]);
      if (k < 3) tick(19);
    end
    tick(2);
    check("arst_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", data_out, 72'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_valid", frame_valid, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    run_vec(0, 1'b1);

    // Pulse totals over the whole run
    check("total_crc_err", cnt_crc, 2);
    check("total_timeout_err", cnt_tmo, 1);
    check("total_overrun_err", cnt_ovr, 2);
    check("total_frame_err", cnt_fe, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
